elevator_ctrl_n: RTL and testbench
==================================

ELEVATOR_CTRL_N -- requirements
Module: elevator_ctrl_n

Interface
REQ-001 SHALL provide parameter NUM_FLOORS, default 8, number of floors (>= 2), floor 0 = bottom.
REQ-002 SHALL provide parameter DOOR_CYCLES, default 16, clock cycles the door stays open (>= 2).
REQ-003 SHALL derive localparam FLOOR_W = max(1, $clog2(NUM_FLOORS)).
REQ-004 SHALL have ports as listed below, one per line: name, direction, width, meaning.
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high.
- floor_sensor  input  NUM_FLOORS  one-hot car-at-floor sensors.
- hall_up  input  NUM_FLOORS  hall up buttons; bit NUM_FLOORS-1 ignored.
- hall_dn  input  NUM_FLOORS  hall down buttons; bit 0 ignored.
- car_call  input  NUM_FLOORS  in-car floor buttons.
- door_hold  input  1  door-open button; reloads the door timer while in DOOR.
- motor_up  output  1  drive up.
- motor_dn  output  1  drive down.
- door_open  output  1  door open.
- cur_floor  output  FLOOR_W  last valid floor index.
- dir_up  output  1  committed direction, 1 = up.
- pend_up, pend_dn, pend_car  output  NUM_FLOORS each  latched request registers.

Function
REQ-005 SHALL be a Moore FSM with states IDLE, MOVE_UP, MOVE_DN, DOOR; all outputs SHALL be decoded from registers only.
REQ-006 SHALL assert motor_up iff MOVE_UP, motor_dn iff MOVE_DN, door_open iff DOOR; at most one of the three SHALL be high.
REQ-007 SHALL OR button inputs into the pend_* registers on each rising edge; a latched bit SHALL hold until cleared per REQ-013/014.
REQ-008 SHALL update cur_floor only when floor_sensor is exactly one-hot; zero-hot or multi-hot SHALL hold cur_floor.
REQ-009 SHALL define "ahead" as any pend bit at an index strictly above (if dir_up) or strictly below (if !dir_up) cur_floor.
REQ-010 IDLE: a pend bit at cur_floor SHALL go to DOOR; otherwise requests ahead in dir_up SHALL move that way; otherwise requests opposite SHALL flip dir_up and move; otherwise stay IDLE. The transition SHALL occur on the edge after the pend bit is visible.
REQ-011 MOVE_UP: on an edge where the sensor is one-hot at floor f and (pend_car[f] or pend_up[f] or f = NUM_FLOORS-1 or no pend bit above f), the next state SHALL be DOOR; MOVE_DN SHALL be symmetric (pend_dn, floor 0, none below).
REQ-012 DOOR: the timer SHALL load DOOR_CYCLES-1 on entry and decrement each cycle; the state SHALL exit on the edge where it reads 0, so door_open SHALL be high exactly DOOR_CYCLES cycles absent reloads.
REQ-013 SHALL clear pend_car[cur_floor] and the hall bit at cur_floor in direction dir_up every cycle in DOOR; a matching press in DOOR SHALL reload the timer and SHALL not stay latched.
REQ-014 At DOOR timer expiry: requests ahead SHALL go to MOVE in dir_up; else, if the opposite hall bit at cur_floor is pending, SHALL flip dir_up, clear that bit and reload the timer (stay DOOR); else requests opposite SHALL flip dir_up and move; else go to IDLE.
REQ-015 door_hold high in DOOR SHALL reload the timer each cycle; door_hold SHALL be ignored in other states.
REQ-016 Simultaneous set and clear of one pend bit SHALL resolve to clear.

Reset
REQ-017 reset SHALL asynchronously force IDLE, all pend_* = 0, cur_floor = 0, dir_up = 1, timer = 0, and all motor/door outputs = 0, including mid-move.
REQ-018 The first edge after reset deassertion SHALL resume normal operation with no extra wait state.

Structure
REQ-019 SHALL place the state enum (2-bit) and direction constants in shared package elevator_pkg.
REQ-020 SHALL implement the door countdown as sub-module door_timer (load, count, expired).

Verification (NUM_FLOORS=4, DOOR_CYCLES=4)
REQ-021 reset, sensor=0001, car_call[2] pulsed 1 cycle -> pend_car=0100 next cycle; motor_up the cycle after; sensor=0100 -> DOOR, door_open 4 cycles, pend_car=0000, then IDLE.
REQ-022 At floor 0, hall_dn[3] and car_call[1] both pending -> stops at 1 (DOOR), continues to 3, DOOR, dir_up=0, IDLE.
REQ-023 DOOR at floor 2 going up with hall_dn[2] pending, nothing above -> door_open stays high 8 cycles total, dir_up flips to 0, pend_dn[2] clears.
REQ-024 door_hold held 5 cycles mid-DOOR -> door_open lasts 5 + 4 cycles after release; a repeat car_call at cur_floor in DOOR reloads the timer.
REQ-025 reset asserted during MOVE_UP -> motor_up falls the same cycle, all pend_* = 0, cur_floor = 0.
REQ-026 floor_sensor = 0110 or 0000 during a move -> cur_floor holds, no stop decision taken.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator controller slice.
package elevator_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StMoveUp = 2'd1,
    StMoveDn = 2'd2,
    StDoor   = 2'd3
  } state_e;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/door_timer.sv
// Door-open countdown: load to CYCLES-1, count down to zero, flag expiry at zero.
module door_timer #(
  parameter int unsigned CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic count,
  output logic expired
);

  localparam int unsigned W = ($clog2(CYCLES) > 0) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] LOAD_VAL = W'(CYCLES - 1);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= LOAD_VAL;
    end else if (count && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/elevator_ctrl_n.sv
// Single-car collective elevator controller: latched requests, Moore FSM, door countdown.
module elevator_ctrl_n
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS  = 8,
  parameter int DOOR_CYCLES = 16,
  localparam int FLOOR_W    = ($clog2(NUM_FLOORS) > 1) ? $clog2(NUM_FLOORS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] floor_sensor,
  input  logic [NUM_FLOORS-1:0] hall_up,
  input  logic [NUM_FLOORS-1:0] hall_dn,
  input  logic [NUM_FLOORS-1:0] car_call,
  input  logic                  door_hold,
  output logic                  motor_up,
  output logic                  motor_dn,
  output logic                  door_open,
  output logic [FLOOR_W-1:0]    cur_floor,
  output logic                  dir_up,
  output logic [NUM_FLOORS-1:0] pend_up,
  output logic [NUM_FLOORS-1:0] pend_dn,
  output logic [NUM_FLOORS-1:0] pend_car
);

  // Top floor has no up button, bottom floor no down button.
  localparam logic [NUM_FLOORS-1:0] UP_MASK = {1'b0, {(NUM_FLOORS-1){1'b1}}};
  localparam logic [NUM_FLOORS-1:0] DN_MASK = {{(NUM_FLOORS-1){1'b1}}, 1'b0};

  state_e                state_q, state_d;
  logic                  dir_up_q, dir_up_d;
  logic [FLOOR_W-1:0]    cur_floor_q, cur_floor_d;
  logic [NUM_FLOORS-1:0] pend_up_q, pend_dn_q, pend_car_q;
  logic [NUM_FLOORS-1:0] clr_up, clr_dn, clr_car;
  logic [NUM_FLOORS-1:0] hall_up_m, hall_dn_m, pend_all;
  logic [FLOOR_W-1:0]    sidx;
  logic                  sensor_ok, ahead, behind, at_cur, opp_hall, match_press;
  logic                  tmr_load, tmr_count, tmr_expired;

  function automatic logic any_above(input logic [NUM_FLOORS-1:0] v,
                                     input logic [FLOOR_W-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if ((i > int'(f)) && v[i]) r = 1'b1;
    end
    return r;
  endfunction

  function automatic logic any_below(input logic [NUM_FLOORS-1:0] v,
                                     input logic [FLOOR_W-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if ((i < int'(f)) && v[i]) r = 1'b1;
    end
    return r;
  endfunction

  assign hall_up_m = hall_up & UP_MASK;
  assign hall_dn_m = hall_dn & DN_MASK;
  assign pend_all  = pend_up_q | pend_dn_q | pend_car_q;
  assign sensor_ok = $onehot(floor_sensor);

  always_comb begin
    sidx = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (floor_sensor[i]) sidx = FLOOR_W'(i);
    end
  end

  assign cur_floor_d = sensor_ok ? sidx : cur_floor_q;
  assign ahead    = dir_up_q ? any_above(pend_all, cur_floor_q) : any_below(pend_all, cur_floor_q);
  assign behind   = dir_up_q ? any_below(pend_all, cur_floor_q) : any_above(pend_all, cur_floor_q);
  assign at_cur   = pend_all[cur_floor_q];
  assign opp_hall = dir_up_q ? pend_dn_q[cur_floor_q] : pend_up_q[cur_floor_q];
  assign match_press = car_call[cur_floor_q] |
                       (dir_up_q ? hall_up_m[cur_floor_q] : hall_dn_m[cur_floor_q]);

  always_comb begin
    state_d   = state_q;
    dir_up_d  = dir_up_q;
    tmr_load  = 1'b0;
    tmr_count = 1'b0;
    clr_up    = '0;
    clr_dn    = '0;
    clr_car   = '0;
    unique case (state_q)
      StIdle: begin
        if (at_cur) begin
          state_d  = StDoor;
          tmr_load = 1'b1;
        end else if (ahead) begin
          state_d = dir_up_q ? StMoveUp : StMoveDn;
        end else if (behind) begin
          dir_up_d = ~dir_up_q;
          state_d  = dir_up_q ? StMoveDn : StMoveUp;
        end
      end
      StMoveUp: begin
        if (sensor_ok && (pend_car_q[sidx] || pend_up_q[sidx] ||
            (int'(sidx) == NUM_FLOORS - 1) || !any_above(pend_all, sidx))) begin
          state_d  = StDoor;
          tmr_load = 1'b1;
        end
      end
      StMoveDn: begin
        if (sensor_ok && (pend_car_q[sidx] || pend_dn_q[sidx] ||
            (sidx == '0) || !any_below(pend_all, sidx))) begin
          state_d  = StDoor;
          tmr_load = 1'b1;
        end
      end
      StDoor: begin
        // Requests served at this floor are dropped while the door is open.
        clr_car[cur_floor_q] = 1'b1;
        if (dir_up_q) clr_up[cur_floor_q] = 1'b1;
        else          clr_dn[cur_floor_q] = 1'b1;
        if (door_hold || match_press) begin
          tmr_load = 1'b1;
        end else if (tmr_expired) begin
          if (ahead) begin
            state_d = dir_up_q ? StMoveUp : StMoveDn;
          end else if (opp_hall) begin
            // Reopen for the passengers waiting to travel the other way.
            dir_up_d = ~dir_up_q;
            tmr_load = 1'b1;
            if (dir_up_q) clr_dn[cur_floor_q] = 1'b1;
            else          clr_up[cur_floor_q] = 1'b1;
          end else if (behind) begin
            dir_up_d = ~dir_up_q;
            state_d  = dir_up_q ? StMoveDn : StMoveUp;
          end else begin
            state_d = StIdle;
          end
        end else begin
          tmr_count = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      dir_up_q    <= DIR_UP;
      cur_floor_q <= '0;
      pend_up_q   <= '0;
      pend_dn_q   <= '0;
      pend_car_q  <= '0;
    end else begin
      state_q     <= state_d;
      dir_up_q    <= dir_up_d;
      cur_floor_q <= cur_floor_d;
      pend_up_q   <= (pend_up_q | hall_up_m) & ~clr_up;
      pend_dn_q   <= (pend_dn_q | hall_dn_m) & ~clr_dn;
      pend_car_q  <= (pend_car_q | car_call) & ~clr_car;
    end
  end

  door_timer #(
    .CYCLES(DOOR_CYCLES)
  ) u_door_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (tmr_load),
    .count  (tmr_count),
    .expired(tmr_expired)
  );

  assign motor_up  = (state_q == StMoveUp);
  assign motor_dn  = (state_q == StMoveDn);
  assign door_open = (state_q == StDoor);
  assign cur_floor = cur_floor_q;
  assign dir_up    = dir_up_q;
  assign pend_up   = pend_up_q;
  assign pend_dn   = pend_dn_q;
  assign pend_car  = pend_car_q;

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// Directed bench for elevator_ctrl_n with 4 floors and a 4-cycle door.
module tb_elevator_ctrl_n;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] floor_sensor, hall_up, hall_dn, car_call;
  logic       door_hold;
  logic       motor_up, motor_dn, door_open, dir_up;
  logic [1:0] cur_floor;
  logic [3:0] pend_up, pend_dn, pend_car;

  int checks = 0;
  int errors = 0;
  int n;

  elevator_ctrl_n #(
    .NUM_FLOORS (4),
    .DOOR_CYCLES(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .floor_sensor(floor_sensor),
    .hall_up     (hall_up),
    .hall_dn     (hall_dn),
    .car_call    (car_call),
    .door_hold   (door_hold),
    .motor_up    (motor_up),
    .motor_dn    (motor_dn),
    .door_open   (door_open),
    .cur_floor   (cur_floor),
    .dir_up      (dir_up),
    .pend_up     (pend_up),
    .pend_dn     (pend_dn),
    .pend_car    (pend_car)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counts consecutive door-open samples, starting with the current one.
  task automatic count_open(output int cnt);
    cnt = 0;
    while (door_open && cnt < 40) begin
      cnt++;
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; floor_sensor = 4'b0001; hall_up = '0; hall_dn = '0;
    car_call = '0; door_hold = 1'b0;
    #12;
    check("rst_motor", 32'({motor_up, motor_dn, door_open}), 32'h0);
    check("rst_pend", 32'({pend_up, pend_dn, pend_car}), 32'h0);
    check("rst_floor", 32'(cur_floor), 32'h0);
    check("rst_dir", 32'(dir_up), 32'h1);
    tick();
    reset = 1'b0;

    // Single car call to floor 2.
    car_call = 4'b0100; tick();
    check("t1_latch", 32'(pend_car), 32'h4);
    check("t1_idle", 32'(motor_up), 32'h0);
    car_call = 4'b0000; tick();
    check("t1_go", 32'(motor_up), 32'h1);
    floor_sensor = 4'b0010; tick();
    check("t1_pass1", 32'({motor_up, door_open}), 32'h2);
    check("t1_floor1", 32'(cur_floor), 32'h1);
    floor_sensor = 4'b0100; tick();
    check("t1_door", 32'({motor_up, door_open}), 32'h1);
    check("t1_floor2", 32'(cur_floor), 32'h2);
    tick();
    check("t1_clear", 32'(pend_car), 32'h0);
    tick(); tick();
    check("t1_open4", 32'(door_open), 32'h1);
    tick();
    check("t1_idle_end", 32'({motor_up, motor_dn, door_open}), 32'h0);

    // Going down with invalid sensor patterns on the way.
    car_call = 4'b0011; tick();
    car_call = 4'b0000; tick();
    check("t2_go_dn", 32'({motor_dn, dir_up}), 32'h2);
    floor_sensor = 4'b0110; tick();
    check("t2_multi_hold", 32'({cur_floor, motor_dn}), 32'h5);
    floor_sensor = 4'b0000; tick();
    check("t2_zero_hold", 32'({cur_floor, motor_dn}), 32'h5);
    floor_sensor = 4'b0010; tick();
    check("t2_stop1", 32'({cur_floor, door_open}), 32'h3);
    tick(); tick(); tick(); tick();
    check("t2_resume_dn", 32'({motor_dn, pend_car}), 32'h11);
    floor_sensor = 4'b0001; tick();
    check("t2_stop0", 32'({cur_floor, door_open}), 32'h1);
    tick(); tick(); tick(); tick();
    check("t2_idle", 32'({motor_up, motor_dn, door_open, pend_car}), 32'h0);

    // Hall down at the top plus car call to 1, starting downward-committed at 0.
    hall_dn = 4'b1000; car_call = 4'b0010; tick();
    check("t3_latch", 32'({pend_dn, pend_car}), 32'h82);
    hall_dn = 4'b0000; car_call = 4'b0000; tick();
    check("t3_flip_up", 32'({motor_up, dir_up}), 32'h3);
    floor_sensor = 4'b0010; tick();
    check("t3_stop1", 32'({cur_floor, door_open}), 32'h3);
    tick(); tick(); tick(); tick();
    check("t3_resume_up", 32'(motor_up), 32'h1);
    floor_sensor = 4'b0100; tick();
    check("t3_pass2", 32'({cur_floor, motor_up}), 32'h5);
    floor_sensor = 4'b1000; tick();
    check("t3_stop3", 32'({cur_floor, door_open}), 32'h7);
    tick(); tick(); tick(); tick();
    check("t3_reopen", 32'({door_open, dir_up, pend_dn}), 32'h20);
    count_open(n);
    check("t3_open_total", 32'(n + 4), 32'd8);
    check("t3_idle_dir", 32'({door_open, dir_up}), 32'h0);

    // door_hold, then a repeat car call at the current floor.
    car_call = 4'b1000; tick();
    car_call = 4'b0000; tick();
    check("t4_door", 32'(door_open), 32'h1);
    tick();
    door_hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_held", 32'(door_open), 32'h1);
    end
    door_hold = 1'b0;
    count_open(n);
    check("t4_after_hold", 32'(n), 32'd4);
    car_call = 4'b1000; tick();
    car_call = 4'b0000; tick();
    tick(); tick();
    car_call = 4'b1000; tick();
    car_call = 4'b0000;
    check("t4_no_latch", 32'(pend_car), 32'h0);
    count_open(n);
    check("t4_reload", 32'(n), 32'd4);

    // Asynchronous reset during an upward move.
    floor_sensor = 4'b0001; reset = 1'b1; tick();
    reset = 1'b0;
    car_call = 4'b0100; tick();
    car_call = 4'b0000; tick();
    check("t5_moving", 32'(motor_up), 32'h1);
    #3 reset = 1'b1;
    #1;
    check("t5_async_motor", 32'(motor_up), 32'h0);
    check("t5_async_pend", 32'({pend_up, pend_dn, pend_car}), 32'h0);
    check("t5_async_floor_dir", 32'({cur_floor, dir_up}), 32'h1);
    tick();
    reset = 1'b0;

    // Ignored hall bits; resumption right after reset.
    hall_up = 4'b1001; hall_dn = 4'b0001; tick();
    check("t6_mask", 32'({pend_up, pend_dn}), 32'h10);
    hall_up = 4'b0000; hall_dn = 4'b0000; tick();
    check("t6_door", 32'(door_open), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
